// File: rtl/hm_tx.sv
// Host-memory read requester: sends one PCIe Memory Read TLP per command on the
// 64-bit TRN TX port, then waits for the receiver's completion pulse or a timeout.
module hm_tx #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        trn_clk,
    input  logic        sys_rst,
    input  logic        hm_start,
    input  logic [63:0] hm_addr,
    input  logic [9:0]  hm_len,
    input  logic [15:0] cfg_completer_id,
    input  logic        rx_memory_read,
    output logic        hm_busy,
    output logic        hm_done,
    output logic        hm_timeout,
    output logic [63:0] trn_td,
    output logic        trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [5:0]  trn_tbuf_av,
    input  logic        trn_lnk_up_n,
    output logic [31:0] stat_trn_cpt_tx,
    output logic [1:0]  stat_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        H0       = 2'd1,
        H1       = 2'd2,
        WAIT_CPL = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [61:0] addr_q, addr_d;
    logic [9:0]  len_q, len_d;
    logic [15:0] id_q, id_d;
    logic [1:0]  fmt_q, fmt_d;
    logic [7:0]  tag_q, tag_d;
    logic [31:0] stat_q, stat_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;

    logic [31:0] dw0, dw1;
    logic [3:0]  lastBe;
    logic [63:0] tdComb;
    logic        tremN, sofN, eofN, srcRdyN;
    logic        unusedBits;

    assign unusedBits = ^{trn_tbuf_av[5:2], trn_tbuf_av[0], hm_addr[1:0]};

    // Header fields come only from latched values so they hold still under backpressure.
    assign lastBe = (len_q == 10'd1) ? 4'h0 : 4'hF;
    assign dw0    = {1'b0, fmt_q, 5'b0, 1'b0, 3'b0, 4'b0, 1'b0, 1'b0, 2'b00, 2'b00, len_q};
    assign dw1    = {id_q, tag_q, lastBe, 4'hF};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        fmt_d   = fmt_q;
        tag_d   = tag_q;
        stat_d  = stat_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        tdComb  = 64'h0;
        tremN   = 1'b1;
        sofN    = 1'b1;
        eofN    = 1'b1;
        srcRdyN = 1'b1;

        case (state_q)
            IDLE: begin
                // A command arriving in the same cycle as a done/timeout pulse is dropped.
                if (hm_start && !trn_lnk_up_n && !done_q && !tmo_q) begin
                    addr_d  = hm_addr[63:2];
                    len_d   = hm_len;
                    id_d    = cfg_completer_id;
                    fmt_d   = (hm_addr[63:32] != 32'h0) ? 2'b01 : 2'b00;
                    state_d = H0;
                end
            end
            H0: begin
                tdComb = {dw0, dw1};
                tremN  = 1'b0;
                sofN   = 1'b0;
                if (trn_lnk_up_n) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    srcRdyN = ~trn_tbuf_av[1];
                    if (trn_tbuf_av[1] && !trn_tdst_rdy_n) begin
                        state_d = H1;
                    end
                end
            end
            H1: begin
                eofN = 1'b0;
                if (fmt_q == 2'b01) begin
                    tdComb = {addr_q[61:30], addr_q[29:0], 2'b00};
                    tremN  = 1'b0;
                end else begin
                    tdComb = {addr_q[29:0], 2'b00, 32'h0};
                    tremN  = 1'b1;
                end
                if (trn_lnk_up_n) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    srcRdyN = 1'b0;
                    if (!trn_tdst_rdy_n) begin
                        stat_d  = stat_q + 32'd1;
                        tag_d   = tag_q + 8'd1;
                        cnt_d   = 16'h0;
                        state_d = WAIT_CPL;
                    end
                end
            end
            WAIT_CPL: begin
                cnt_d = cnt_q + 16'd1;
                if (rx_memory_read) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (trn_lnk_up_n || (cnt_q == TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge trn_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            fmt_q   <= '0;
            tag_q   <= '0;
            stat_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            fmt_q   <= fmt_d;
            tag_q   <= tag_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign hm_busy         = (state_q != IDLE);
    assign hm_done         = done_q;
    assign hm_timeout      = tmo_q;
    assign trn_td          = tdComb;
    assign trn_trem_n      = tremN;
    assign trn_tsof_n      = sofN;
    assign trn_teof_n      = eofN;
    assign trn_tsrc_rdy_n  = srcRdyN;
    assign trn_tsrc_dsc_n  = 1'b1;
    assign stat_trn_cpt_tx = stat_q;
    assign stat_state      = state_q;

endmodule

// File: tb/tb_hm_tx.sv
// Self-checking bench for hm_tx: a scoreboard of expected TX beats is filled as
// commands are issued and drained by a monitor whenever a beat is transferred.
module tb_hm_tx;

    logic        trn_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        hm_start = 1'b0;
    logic [63:0] hm_addr = 64'h0;
    logic [9:0]  hm_len = 10'h0;
    logic [15:0] cfg_completer_id = 16'h0100;
    logic        rx_memory_read = 1'b0;
    logic        hm_busy, hm_done, hm_timeout;
    logic [63:0] trn_td;
    logic        trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n = 1'b0;
    logic [5:0]  trn_tbuf_av = 6'h3F;
    logic        trn_lnk_up_n = 1'b0;
    logic [31:0] stat_trn_cpt_tx;
    logic [1:0]  stat_state;

    typedef struct {
        logic [63:0] td;
        logic        trem;
        logic        sof;
        logic        eof;
    } beatT;

    beatT        sbQ[$];
    beatT        monBeat;
    int          assertCount = 0;
    int          failCount = 0;
    int          beatCount = 0;
    logic [7:0]  modelTag = 8'h0;
    logic [31:0] modelStat = 32'h0;
    logic        prevStall = 1'b0;
    logic [63:0] prevTd;
    logic        prevTrem, prevSof, prevEof;

    always #5 trn_clk = ~trn_clk;

    hm_tx #(.TIMEOUT(16'd20)) dut (
        .trn_clk          (trn_clk),
        .sys_rst          (sys_rst),
        .hm_start         (hm_start),
        .hm_addr          (hm_addr),
        .hm_len           (hm_len),
        .cfg_completer_id (cfg_completer_id),
        .rx_memory_read   (rx_memory_read),
        .hm_busy          (hm_busy),
        .hm_done          (hm_done),
        .hm_timeout       (hm_timeout),
        .trn_td           (trn_td),
        .trn_trem_n       (trn_trem_n),
        .trn_tsof_n       (trn_tsof_n),
        .trn_teof_n       (trn_teof_n),
        .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n   (trn_tsrc_dsc_n),
        .trn_tdst_rdy_n   (trn_tdst_rdy_n),
        .trn_tbuf_av      (trn_tbuf_av),
        .trn_lnk_up_n     (trn_lnk_up_n),
        .stat_trn_cpt_tx  (stat_trn_cpt_tx),
        .stat_state       (stat_state)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after the rising edge; the monitor samples on the falling edge.
    task automatic tick();
        @(posedge trn_clk);
        #1;
    endtask

    always @(negedge trn_clk) begin
        if (!sys_rst) begin
            if (prevStall) begin
                checkOutput("stallTd", trn_td, prevTd);
                checkOutput("stallTrem", trn_trem_n, prevTrem);
                checkOutput("stallSof", trn_tsof_n, prevSof);
                checkOutput("stallEof", trn_teof_n, prevEof);
            end
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                beatCount++;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedBeat", 64'd1, 64'd0);
                end else begin
                    monBeat = sbQ.pop_front();
                    checkOutput("beatTd", trn_td, monBeat.td);
                    checkOutput("beatTrem", trn_trem_n, monBeat.trem);
                    checkOutput("beatSof", trn_tsof_n, monBeat.sof);
                    checkOutput("beatEof", trn_teof_n, monBeat.eof);
                end
            end
        end
        prevStall = !sys_rst && !trn_tsrc_rdy_n && trn_tdst_rdy_n;
        prevTd    = trn_td;
        prevTrem  = trn_trem_n;
        prevSof   = trn_tsof_n;
        prevEof   = trn_teof_n;
    end

    task automatic pushBeat(input logic [63:0] td, input logic trem, input logic sof, input logic eof);
        beatT b;
        b.td = td;
        b.trem = trem;
        b.sof = sof;
        b.eof = eof;
        sbQ.push_back(b);
    endtask

    task automatic pushModel(input logic [63:0] addr, input logic [9:0] len, input int nBeats);
        logic [1:0]  fmt;
        logic [3:0]  lastBe;
        logic [31:0] dw0, dw1;
        fmt    = (addr[63:32] != 32'h0) ? 2'b01 : 2'b00;
        lastBe = (len == 10'd1) ? 4'h0 : 4'hF;
        dw0    = {1'b0, fmt, 5'b0, 1'b0, 3'b0, 4'b0, 1'b0, 1'b0, 2'b00, 2'b00, len};
        dw1    = {cfg_completer_id, modelTag, lastBe, 4'hF};
        pushBeat({dw0, dw1}, 1'b0, 1'b0, 1'b1);
        if (nBeats > 1) begin
            if (fmt == 2'b01) pushBeat({addr[63:32], addr[31:2], 2'b00}, 1'b0, 1'b1, 1'b0);
            else              pushBeat({addr[31:2], 2'b00, 32'h0}, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] addr, input logic [9:0] len);
        hm_addr  = addr;
        hm_len   = len;
        hm_start = 1'b1;
        tick();
        hm_start = 1'b0;
    endtask

    task automatic waitQueueEmpty(input int bound);
        int n = 0;
        while (sbQ.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (sbQ.size() != 0) checkOutput("beatWaitExpired", 64'(sbQ.size()), 64'd0);
    endtask

    // Returns just after the edge that moved the DUT into WAIT_CPL.
    task automatic completeTx();
        waitQueueEmpty(50);
        modelTag++;
        modelStat++;
        checkOutput("statCount", stat_trn_cpt_tx, modelStat);
        checkOutput("stateWait", stat_state, 64'd3);
    endtask

    task automatic sendRead(input logic [63:0] addr, input logic [9:0] len);
        pushModel(addr, len, 2);
        applyStimulus(addr, len);
        completeTx();
    endtask

    task automatic finishRead(input int delay);
        repeat (delay) tick();
        rx_memory_read = 1'b1;
        tick();
        rx_memory_read = 1'b0;
        checkOutput("donePulse", hm_done, 64'd1);
        checkOutput("doneBusy", hm_busy, 64'd0);
        checkOutput("doneNoTmo", hm_timeout, 64'd0);
        tick();
        checkOutput("doneOneCycle", hm_done, 64'd0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstBusy", hm_busy, 64'd0);
        checkOutput("rstDone", hm_done, 64'd0);
        checkOutput("rstTmo", hm_timeout, 64'd0);
        checkOutput("rstTd", trn_td, 64'd0);
        checkOutput("rstTrem", trn_trem_n, 64'd1);
        checkOutput("rstSof", trn_tsof_n, 64'd1);
        checkOutput("rstEof", trn_teof_n, 64'd1);
        checkOutput("rstSrcRdy", trn_tsrc_rdy_n, 64'd1);
        checkOutput("rstDsc", trn_tsrc_dsc_n, 64'd1);
        checkOutput("rstStat", stat_trn_cpt_tx, 64'd0);
        checkOutput("rstState", stat_state, 64'd0);
    endtask

    task automatic resetDut();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        modelTag = 8'h0;
        modelStat = 32'h0;
        sbQ.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int startBeats;

        resetDut();
        checkResetOutputs();

        // 3DW read with the reference header values.
        pushBeat(64'h0000_0004_0100_00FF, 1'b0, 1'b0, 1'b1);
        pushBeat(64'h1234_5678_0000_0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(64'h0000_0000_1234_5678, 10'd4);
        completeTx();
        finishRead(10);

        // 4DW read of a single DW, tag back at 0.
        resetDut();
        pushBeat(64'h2000_0001_0100_000F, 1'b0, 1'b0, 1'b1);
        pushBeat(64'h0000_0001_0000_1000, 1'b0, 1'b1, 1'b0);
        applyStimulus(64'h0000_0001_0000_1000, 10'd1);
        completeTx();
        finishRead(2);

        // Destination backpressure on both header beats.
        trn_tdst_rdy_n = 1'b1;
        pushModel(64'h0000_0000_ABCD_EF00, 10'd8, 2);
        startBeats = beatCount;
        applyStimulus(64'h0000_0000_ABCD_EF00, 10'd8);
        repeat (5) tick();
        trn_tdst_rdy_n = 1'b0;
        tick();
        trn_tdst_rdy_n = 1'b1;
        repeat (3) tick();
        trn_tdst_rdy_n = 1'b0;
        completeTx();
        checkOutput("bpBeats", 64'(beatCount - startBeats), 64'd2);
        finishRead(1);

        // No non-posted buffer space: source ready must stay deasserted.
        trn_tbuf_av = 6'h3D;
        pushModel(64'h0000_0000_0000_0400, 10'd0, 2);
        applyStimulus(64'h0000_0000_0000_0400, 10'd0);
        repeat (4) begin
            tick();
            checkOutput("tbufHold", trn_tsrc_rdy_n, 64'd1);
        end
        checkOutput("tbufState", stat_state, 64'd1);
        trn_tbuf_av = 6'h3F;
        completeTx();
        finishRead(3);

        // Timeout expiry with no completion.
        sendRead(64'h0000_0000_0000_2000, 10'd16);
        cycles = 0;
        while (!hm_timeout && cycles < 100) begin
            tick();
            cycles++;
        end
        checkOutput("tmoLatency", 64'(cycles), 64'd21);
        checkOutput("tmoNoDone", hm_done, 64'd0);
        checkOutput("tmoBusy", hm_busy, 64'd0);
        tick();
        checkOutput("tmoOneCycle", hm_timeout, 64'd0);

        // Completion in the expiry cycle wins; a start in the done cycle is dropped.
        sendRead(64'h0000_0000_0000_3000, 10'd2);
        repeat (20) tick();
        rx_memory_read = 1'b1;
        tick();
        rx_memory_read = 1'b0;
        checkOutput("tieDone", hm_done, 64'd1);
        checkOutput("tieNoTmo", hm_timeout, 64'd0);
        hm_start = 1'b1;
        tick();
        hm_start = 1'b0;
        checkOutput("tieNoTmoLate", hm_timeout, 64'd0);
        checkOutput("startOnDoneIgnored", stat_state, 64'd0);
        repeat (2) tick();
        checkOutput("startOnDoneIdle", stat_state, 64'd0);

        // Start with link down is ignored.
        trn_lnk_up_n = 1'b1;
        applyStimulus(64'h0000_0000_0000_5000, 10'd4);
        tick();
        checkOutput("lnkDownStart", stat_state, 64'd0);
        trn_lnk_up_n = 1'b0;

        // Tag wrap across 256 reads, then one more with tag 0.
        resetDut();
        for (int i = 0; i < 256; i++) begin
            sendRead({32'h0, 20'h0, i[9:0], 2'b00}, 10'((i % 7) + 1));
            finishRead(0);
        end
        checkOutput("tagWrapModel", stat_trn_cpt_tx, 64'd256);
        sendRead(64'h0000_0002_0000_0040, 10'd3);

        // Start during WAIT_CPL must not launch another TLP.
        hm_start = 1'b1;
        hm_addr  = 64'h0000_0000_0000_7000;
        tick();
        hm_start = 1'b0;
        repeat (3) tick();
        checkOutput("startInWait", stat_trn_cpt_tx, modelStat);
        checkOutput("startInWaitState", stat_state, 64'd3);
        finishRead(0);

        // Link loss while the second header beat is pending.
        trn_tdst_rdy_n = 1'b1;
        pushModel(64'h0000_0000_0000_8000, 10'd5, 1);
        applyStimulus(64'h0000_0000_0000_8000, 10'd5);
        trn_tdst_rdy_n = 1'b0;
        tick();
        trn_tdst_rdy_n = 1'b1;
        trn_lnk_up_n = 1'b1;
        tick();
        checkOutput("lnkLossTmo", hm_timeout, 64'd1);
        checkOutput("lnkLossState", stat_state, 64'd0);
        checkOutput("lnkLossStat", stat_trn_cpt_tx, modelStat);
        trn_lnk_up_n = 1'b0;
        trn_tdst_rdy_n = 1'b0;
        tick();
        checkOutput("lnkLossOneCycle", hm_timeout, 64'd0);
        checkOutput("lnkLossQueue", 64'(sbQ.size()), 64'd0);
        sendRead(64'h0000_0000_0000_9000, 10'd6);
        finishRead(1);

        // Reset in the middle of WAIT_CPL, then the tag restarts at 0.
        sendRead(64'h0000_0000_0000_A000, 10'd2);
        repeat (3) tick();
        sys_rst = 1'b1;
        tick();
        checkResetOutputs();
        sys_rst = 1'b0;
        modelTag = 8'h0;
        modelStat = 32'h0;
        sbQ.delete();
        tick();
        sendRead(64'h0000_0000_0000_B000, 10'd9);
        finishRead(1);

        checkOutput("finalQueueEmpty", 64'(sbQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
